// File: rtl/pe_array_ctrl_if.sv
// ---------------------------------------------------------------------------
// pe_array_ctrl_if
// Operand and result beat streams between the SRAM movers and pe_array_ctrl.
//   in_valid / in_ready / in_data              operand beats (element 0 in MSBs)
//   out_valid / out_ready / out_data / out_last result beats (same packing)
// Modports: master = mover side, slave = controller side.
// ---------------------------------------------------------------------------
interface pe_array_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW_SIZE   = 16
);
    localparam int unsigned ROW_W = DATA_WIDTH * ROW_SIZE;

    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [ROW_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// ---------------------------------------------------------------------------
// pe_array_ctrl
// Sequencer for the combinational element-wise PE array. Assembles the A and B
// operand vectors from ROW_SIZE-element beats, holds them for PE_LATENCY
// cycles, captures the product bus and streams it back out in beats.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin an operation (sampled in IDLE only)
//   busy, done      status: busy outside IDLE, done pulses on return to IDLE
//   strm            operand/result beat streams (slave modport)
//   pe_A, pe_B      full-width operand buses to the array (element 0 in MSBs)
//   pe_Mul          full-width product bus from the array
// ---------------------------------------------------------------------------
module pe_array_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ARRAY_SIZE = 128,
    parameter int unsigned ROW_SIZE   = 16,
    parameter int unsigned PE_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    pe_array_ctrl_if.slave                   strm,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] pe_A,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] pe_B,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] pe_Mul
);
    localparam int unsigned BEATS  = ARRAY_SIZE / ROW_SIZE;
    localparam int unsigned ROW_W  = DATA_WIDTH * ROW_SIZE;
    localparam int unsigned VEC_W  = DATA_WIDTH * ARRAY_SIZE;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4
    } state_e;

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [VEC_W-1:0]    pe_a_q;
    logic [VEC_W-1:0]    pe_b_q;
    logic [VEC_W-1:0]    result_q;
    logic [ROW_W-1:0]    out_data_q;
    logic                busy_q;
    logic                done_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                out_last_q;

    logic                in_fire;
    logic                out_fire;
    logic                last_beat;
    logic [BEAT_W-1:0]   beat_next;

    // MSB index of beat k within a full vector; beat 0 occupies the top bits.
    function automatic int unsigned slice_msb(input logic [BEAT_W-1:0] k);
        return VEC_W - 32'd1 - ROW_W * 32'(k);
    endfunction

    assign in_fire   = strm.in_valid & in_ready_q;
    assign out_fire  = out_valid_q & strm.out_ready;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign beat_next = beat_q + BEAT_W'(1);

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
            result_q    <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD_A;
                        beat_q     <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end

                LOAD_A: begin
                    if (in_fire) begin
                        pe_a_q[slice_msb(beat_q) -: ROW_W] <= strm.in_data;
                        if (last_beat) begin
                            beat_q  <= '0;
                            state_q <= LOAD_B;
                        end else begin
                            beat_q <= beat_next;
                        end
                    end
                end

                LOAD_B: begin
                    if (in_fire) begin
                        pe_b_q[slice_msb(beat_q) -: ROW_W] <= strm.in_data;
                        if (last_beat) begin
                            beat_q     <= '0;
                            wait_q     <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= COMPUTE;
                        end else begin
                            beat_q <= beat_next;
                        end
                    end
                end

                COMPUTE: begin
                    // Operands have been stable for PE_LATENCY cycles by the
                    // final wait cycle; beat 0 is taken straight off the bus.
                    if (wait_q == WAIT_W'(PE_LATENCY - 1)) begin
                        result_q    <= pe_Mul;
                        out_data_q  <= pe_Mul[VEC_W-1 -: ROW_W];
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'(BEATS == 1);
                        beat_q      <= '0;
                        state_q     <= DRAIN;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                DRAIN: begin
                    if (out_fire) begin
                        if (last_beat) begin
                            beat_q      <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            beat_q     <= beat_next;
                            out_data_q <= result_q[slice_msb(beat_next) -: ROW_W];
                            out_last_q <= (beat_next == BEAT_W'(BEATS - 1));
                        end
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    beat_q      <= '0;
                    wait_q      <= '0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_last  = out_last_q;
    assign pe_A           = pe_a_q;
    assign pe_B           = pe_b_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_array_ctrl
// Scoreboard bench for pe_array_ctrl. A stand-in bf16 array model drives
// pe_Mul from pe_A/pe_B; expected result beats are hand-derived constants
// pushed per operation and popped by a monitor on each accepted output beat.
// A second instance built with PE_LATENCY=3 runs one operation alongside the
// default instance to measure the extra compute delay.
// ---------------------------------------------------------------------------
module tb_pe_array_ctrl;
    localparam int DW    = 16;
    localparam int AS    = 128;
    localparam int RS    = 16;
    localparam int BEATS = AS / RS;
    localparam int ROW_W = DW * RS;
    localparam int VEC_W = DW * AS;

    typedef struct packed {
        logic [ROW_W-1:0] data;
        logic             last;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             lat_en;
    logic             start3;
    logic             busy, done, busy3, done3;
    logic [VEC_W-1:0] pe_a, pe_b, pe_mul;
    logic [VEC_W-1:0] pe_a3, pe_b3, pe_mul3;

    int unsigned cyc;
    int          n_tests;
    int          n_fail;
    int          done_cnt;
    int unsigned start_cyc;
    int unsigned ov_rise;
    int unsigned ov3_rise;
    logic        ov_prev;
    logic        ov3_prev;
    bit          toggle_mode;
    beat_t       exp_q[$];

    pe_array_ctrl_if #(.DATA_WIDTH(DW), .ROW_SIZE(RS)) bus ();
    pe_array_ctrl_if #(.DATA_WIDTH(DW), .ROW_SIZE(RS)) bus3 ();

    assign start3         = start & lat_en;
    assign bus3.in_valid  = bus.in_valid;
    assign bus3.in_data   = bus.in_data;
    assign bus3.out_ready = bus.out_ready;

    pe_array_ctrl #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ROW_SIZE(RS), .PE_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .strm(bus), .pe_A(pe_a), .pe_B(pe_b), .pe_Mul(pe_mul)
    );

    pe_array_ctrl #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .ROW_SIZE(RS), .PE_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .strm(bus3), .pe_A(pe_a3), .pe_B(pe_b3), .pe_Mul(pe_mul3)
    );

    // Stand-in bf16 multiplier: 1.0 is exact identity, otherwise truncating.
    function automatic logic [15:0] bf_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [15:0] p;
        logic [6:0]  m;
        if (b == 16'h3F80) return a;
        if (a == 16'h3F80) return b;
        s = a[15] ^ b[15];
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        if (p[15]) begin
            e = e + 1;
            m = p[14:8];
        end else begin
            m = p[13:7];
        end
        if (e <= 0)   return {s, 15'h0};
        if (e >= 255) return {s, 8'hFF, 7'h0};
        return {s, 8'(e), m};
    endfunction

    always_comb begin
        pe_mul  = '0;
        pe_mul3 = '0;
        for (int i = 0; i < AS; i++) begin
            pe_mul[VEC_W-1-i*DW -: DW]  = bf_mul(pe_a[VEC_W-1-i*DW -: DW],  pe_b[VEC_W-1-i*DW -: DW]);
            pe_mul3[VEC_W-1-i*DW -: DW] = bf_mul(pe_a3[VEC_W-1-i*DW -: DW], pe_b3[VEC_W-1-i*DW -: DW]);
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VEC_W-1:0] fill(input logic [15:0] v);
        logic [VEC_W-1:0] r;
        for (int i = 0; i < AS; i++) r[VEC_W-1-i*DW -: DW] = v;
        return r;
    endfunction

    task automatic push_expected(input logic [VEC_W-1:0] r);
        beat_t b;
        for (int j = 0; j < BEATS; j++) begin
            b.data = r[VEC_W-1-j*ROW_W -: ROW_W];
            b.last = (j == BEATS - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start();
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [VEC_W-1:0] v, input int nb, input bit rnd);
        int k = 0;
        int guard = 0;
        while (k < nb && guard < 2000) begin
            guard++;
            if (rnd && $urandom_range(1, 0) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = {8{$urandom}};
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = v[VEC_W-1-k*ROW_W -: ROW_W];
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (k < nb) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got %0d beats expected %0d", k, nb);
        end
    endtask

    // Returns at the falling edge of the cycle where done is high.
    task automatic wait_done();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done && guard < 500);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 500 cycles");
        end
    endtask

    task automatic run_op(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                          input logic [VEC_W-1:0] r, input bit rnd, input bit poke);
        push_expected(r);
        do_start();
        if (poke) begin
            fork
                begin
                    repeat (12) @(posedge clk);
                    #2 start = 1'b1;
                    @(posedge clk);
                    #2 start = 1'b0;
                    repeat (7) @(posedge clk);
                    #2 start = 1'b1;
                    @(posedge clk);
                    #2 start = 1'b0;
                end
            join_none
        end
        send_vec(a, BEATS, rnd);
        send_vec(b, BEATS, rnd);
        wait_done();
    endtask

    initial begin
        logic [VEC_W-1:0] ramp;
        logic [VEC_W-1:0] a_basic, b_one;
        int guard;

        n_tests      = 0;
        n_fail       = 0;
        done_cnt     = 0;
        ov_rise      = 0;
        ov3_rise     = 0;
        ov_prev      = 1'b0;
        ov3_prev     = 1'b0;
        toggle_mode  = 1'b0;
        lat_en       = 1'b0;
        rst          = 1'b1;
        start        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;

        a_basic = fill(16'h4000);
        b_one   = fill(16'h3F80);
        for (int i = 0; i < AS; i++) ramp[VEC_W-1-i*DW -: DW] = 16'(i);

        // Monitor: scoreboard pop on accepted beats, stall check, done count.
        fork
            forever begin
                beat_t e;
                @(negedge clk);
                if (!rst && bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %h expected no beat", bus.out_data);
                    end else if (bus.out_ready) begin
                        e = exp_q.pop_front();
                        check("beat_data", bus.out_data, e.data);
                        check("beat_last", ROW_W'(bus.out_last), ROW_W'(e.last));
                    end else begin
                        check("stall_data", bus.out_data, exp_q[0].data);
                        check("stall_last", ROW_W'(bus.out_last), ROW_W'(exp_q[0].last));
                    end
                end
                if (!rst && done) done_cnt++;
                if (bus.out_valid && !ov_prev) ov_rise = cyc;
                if (bus3.out_valid && !ov3_prev) ov3_rise = cyc;
                ov_prev  = bus.out_valid;
                ov3_prev = bus3.out_valid;
            end
            forever begin
                @(posedge clk);
                #1;
                bus.out_ready = toggle_mode ? ~bus.out_ready : 1'b1;
            end
        join_none

        // Reset held for three cycles with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_flags", ROW_W'({busy, done, bus.in_ready, bus.out_valid, bus.out_last}), '0);
            check("reset_out_data", bus.out_data, '0);
            check("reset_pe_zero", ROW_W'(pe_a == '0 && pe_b == '0), ROW_W'(1));
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;

        // Basic op with latency checks.
        run_op(a_basic, b_one, a_basic, 1'b0, 1'b0);
        check("basic_done_cycle", ROW_W'(cyc - start_cyc), ROW_W'(26));
        check("basic_valid_cycle", ROW_W'(ov_rise - start_cyc), ROW_W'(18));

        // Packing op started in the done cycle of the previous op.
        push_expected(ramp);
        do_start();
        @(negedge clk);
        check("b2b_accepted", ROW_W'({busy, bus.in_ready}), ROW_W'(2'b11));
        @(posedge clk);
        #1;
        send_vec(ramp, BEATS, 1'b0);
        send_vec(b_one, BEATS, 1'b0);
        wait_done();
        @(negedge clk);
        check("pack_done_count", ROW_W'(done_cnt), ROW_W'(2));

        // Backpressure on both streams.
        toggle_mode = 1'b1;
        run_op(a_basic, b_one, a_basic, 1'b1, 1'b0);
        toggle_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_done_once", ROW_W'(done_cnt), ROW_W'(3));

        // Start pulses during LOAD_B and DRAIN must be ignored.
        run_op(ramp, b_one, ramp, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("poke_done_once", ROW_W'(done_cnt), ROW_W'(4));
        check("poke_idle_after", ROW_W'({busy, bus.in_ready}), '0);

        // Reset during LOAD_B after three B beats.
        do_start();
        send_vec(fill(16'h1234), BEATS, 1'b0);
        send_vec(fill(16'h5678), 3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_flags", ROW_W'({busy, done, bus.in_ready, bus.out_valid, bus.out_last}), '0);
        check("midrst_pe_zero", ROW_W'(pe_a == '0 && pe_b == '0), ROW_W'(1));

        // Fresh op; the PE_LATENCY=3 instance runs alongside it.
        lat_en = 1'b1;
        run_op(a_basic, fill(16'h4040), fill(16'h40C0), 1'b0, 1'b0);
        lat_en = 1'b0;
        check("fresh_done_cycle", ROW_W'(cyc - start_cyc), ROW_W'(26));
        check("lat1_valid_cycle", ROW_W'(ov_rise - start_cyc), ROW_W'(18));
        check("lat3_valid_cycle", ROW_W'(ov3_rise - start_cyc), ROW_W'(20));
        guard = 0;
        while (!done3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("lat3_done_cycle", ROW_W'(cyc - start_cyc), ROW_W'(28));
        repeat (2) @(negedge clk);
        check("total_done_count", ROW_W'(done_cnt), ROW_W'(5));
        check("scoreboard_empty", ROW_W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
